// File: rtl/ttt_turn_scheduler.sv
// Turn sequencer and board owner for the 3x3 game: arbitrates player/PC moves, enforces legality,
// forces a player move on timeout and evaluates win/draw after every commit.
module ttt_turn_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned CNT_W          = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        pl_valid,
    input  logic [8:0]  pl_sel,
    input  logic        pc_valid,
    input  logic [8:0]  pc_sel,
    output logic        pc_req,
    output logic [17:0] board,
    output logic        turn,
    output logic [1:0]  status,
    output logic        game_over,
    output logic        illegal,
    output logic        forced
);

    localparam int unsigned CELLS   = 9;
    localparam int unsigned BOARD_W = 2 * CELLS;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_PL    = 2'b01;
    localparam logic [1:0] CELL_PC    = 2'b10;

    localparam logic [1:0] ST_PLAY   = 2'b00;
    localparam logic [1:0] ST_PL_WIN = 2'b01;
    localparam logic [1:0] ST_PC_WIN = 2'b10;
    localparam logic [1:0] ST_DRAW   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        P_WAIT,
        PC_WAIT,
        EVAL,
        DONE
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   count, count_d;
    logic [BOARD_W-1:0] board_d;
    logic               turn_d;
    logic [1:0]         status_d;
    logic               pc_req_d;
    logic               game_over_d;
    logic               illegal_d;
    logic               forced_d;

    logic [CELLS-1:0]   empty_m, pl_m, pc_m, low_empty;
    logic               pl_legal, pc_legal;

    // Any of the 8 lines (rows, columns, diagonals) fully set in an ownership mask.
    function automatic logic has_line(input logic [CELLS-1:0] m);
        return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
               (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
    endfunction

    function automatic logic [BOARD_W-1:0] place(input logic [BOARD_W-1:0] b,
                                                  input logic [CELLS-1:0]   sel,
                                                  input logic [1:0]         code);
        logic [BOARD_W-1:0] r;
        r = b;
        for (int i = 0; i < int'(CELLS); i++) begin
            if (sel[i]) r[2*i +: 2] = code;
        end
        return r;
    endfunction

    // Per-cell ownership masks and the lowest-index empty cell for forced moves.
    always_comb begin
        empty_m   = '0;
        pl_m      = '0;
        pc_m      = '0;
        low_empty = '0;
        for (int i = 0; i < int'(CELLS); i++) begin
            empty_m[i] = (board[2*i +: 2] == CELL_EMPTY);
            pl_m[i]    = (board[2*i +: 2] == CELL_PL);
            pc_m[i]    = (board[2*i +: 2] == CELL_PC);
        end
        for (int i = int'(CELLS) - 1; i >= 0; i--) begin
            if (empty_m[i]) begin
                low_empty    = '0;
                low_empty[i] = 1'b1;
            end
        end
    end

    assign pl_legal = pl_valid && $onehot(pl_sel) && ((pl_sel & empty_m) != '0);
    assign pc_legal = pc_valid && $onehot(pc_sel) && ((pc_sel & empty_m) != '0);

    // Next-state and next-output logic; start overrides everything else.
    always_comb begin
        state_d   = state;
        count_d   = count;
        board_d   = board;
        turn_d    = turn;
        status_d  = status;
        illegal_d = 1'b0;
        forced_d  = 1'b0;

        if (start) begin
            state_d  = P_WAIT;
            count_d  = '0;
            board_d  = '0;
            turn_d   = 1'b0;
            status_d = ST_PLAY;
        end else begin
            case (state)
                IDLE: ;
                P_WAIT: begin
                    count_d = count + CNT_W'(1);
                    if (pl_legal) begin
                        board_d = place(board, pl_sel, CELL_PL);
                        count_d = '0;
                        state_d = EVAL;
                    end else begin
                        illegal_d = pl_valid;
                        if (count == CNT_LAST && empty_m != '0) begin
                            board_d  = place(board, low_empty, CELL_PL);
                            forced_d = 1'b1;
                            count_d  = '0;
                            state_d  = EVAL;
                        end
                    end
                end
                PC_WAIT: begin
                    if (pc_legal) begin
                        board_d = place(board, pc_sel, CELL_PC);
                        state_d = EVAL;
                    end else begin
                        illegal_d = pc_valid;
                    end
                end
                EVAL: begin
                    if (has_line(pl_m)) begin
                        status_d = ST_PL_WIN;
                        state_d  = DONE;
                    end else if (has_line(pc_m)) begin
                        status_d = ST_PC_WIN;
                        state_d  = DONE;
                    end else if (empty_m == '0) begin
                        status_d = ST_DRAW;
                        state_d  = DONE;
                    end else begin
                        turn_d  = ~turn;
                        count_d = '0;
                        state_d = turn ? P_WAIT : PC_WAIT;
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end

        pc_req_d    = (state_d == PC_WAIT);
        game_over_d = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            board     <= '0;
            turn      <= 1'b0;
            status    <= ST_PLAY;
            pc_req    <= 1'b0;
            game_over <= 1'b0;
            illegal   <= 1'b0;
            forced    <= 1'b0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            board     <= board_d;
            turn      <= turn_d;
            status    <= status_d;
            pc_req    <= pc_req_d;
            game_over <= game_over_d;
            illegal   <= illegal_d;
            forced    <= forced_d;
        end
    end

endmodule

// File: tb/tb_ttt_turn_scheduler.sv
// Scoreboard bench for ttt_turn_scheduler: a move-level game model predicts observable events,
// a monitor classifies DUT output changes into events and compares them in order.
module tb_ttt_turn_scheduler;

    localparam int unsigned T  = 8;
    localparam int unsigned CW = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        pl_valid;
    logic [8:0]  pl_sel;
    logic        pc_valid;
    logic [8:0]  pc_sel;
    logic        pc_req;
    logic [17:0] board;
    logic        turn;
    logic [1:0]  status;
    logic        game_over;
    logic        illegal;
    logic        forced;

    ttt_turn_scheduler #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .pl_valid(pl_valid), .pl_sel(pl_sel), .pc_valid(pc_valid), .pc_sel(pc_sel),
        .pc_req(pc_req), .board(board), .turn(turn), .status(status),
        .game_over(game_over), .illegal(illegal), .forced(forced)
    );

    always #5 clock = ~clock;

    typedef enum int {K_RESET, K_CLEAR, K_COMMIT, K_ILLEGAL, K_END, K_TURN, K_OTHER} kind_t;

    typedef struct {
        kind_t       kind;
        logic [17:0] board;
        logic [1:0]  status;
        logic        turn;
        logic        pc_req;
        logic        game_over;
        logic        forced;
        logic        illegal;
    } snap_t;

    snap_t      exp_q[$];
    logic [8:0] bad_q[$];
    int         n_vec = 0;
    int         n_bad = 0;

    // Game model: 0 empty, 1 player, 2 PC.
    int cells[9];
    bit m_turn;
    bit m_over;
    int mv[9];
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic logic [17:0] m_board();
        logic [17:0] b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(cells[i]);
        return b;
    endfunction

    function automatic int m_winner();
        for (int l = 0; l < 8; l++) begin
            if (cells[lines[l][0]] != 0 && cells[lines[l][0]] == cells[lines[l][1]] &&
                cells[lines[l][1]] == cells[lines[l][2]])
                return cells[lines[l][0]];
        end
        return 0;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < 9; i++) if (cells[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [8:0] onehot_of(input int i);
        logic [8:0] s = '0;
        s[i] = 1'b1;
        return s;
    endfunction

    function automatic int sel_index(input logic [8:0] s);
        for (int i = 0; i < 9; i++) if (s[i]) return i;
        return 0;
    endfunction

    function automatic int lowest_empty();
        for (int i = 0; i < 9; i++) if (cells[i] == 0) return i;
        return 0;
    endfunction

    function automatic logic [8:0] any_onehot();
        return onehot_of(int'($urandom_range(0, 8)));
    endfunction

    function automatic logic [8:0] rand_empty();
        int idx[$];
        for (int i = 0; i < 9; i++) if (cells[i] == 0) idx.push_back(i);
        if (idx.size() == 0) return any_onehot();
        return onehot_of(idx[$urandom_range(0, 32'(idx.size() - 1))]);
    endfunction

    // A selection the rules must reject: not one-hot, or an occupied cell.
    function automatic logic [8:0] bad_sel();
        logic [8:0] s = '0;
        int i, j, occ[$];
        case ($urandom_range(0, 3))
            0: s = '0;
            1: begin
                i = int'($urandom_range(0, 8));
                j = (i + 1 + int'($urandom_range(0, 7))) % 9;
                s[i] = 1'b1;
                s[j] = 1'b1;
            end
            2: begin
                for (int k = 0; k < 9; k++) if (cells[k] != 0) occ.push_back(k);
                if (occ.size() != 0) s = onehot_of(occ[$urandom_range(0, 32'(occ.size() - 1))]);
            end
            default: s = 9'h1FF;
        endcase
        return s;
    endfunction

    function automatic snap_t mk(input kind_t k, input logic [1:0] st, input logic t,
                                 input logic pr, input logic go, input logic f, input logic il);
        snap_t s;
        s.kind = k; s.board = m_board(); s.status = st; s.turn = t;
        s.pc_req = pr; s.game_over = go; s.forced = f; s.illegal = il;
        return s;
    endfunction

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    endtask

    task automatic check_ev(input snap_t g);
        snap_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got board=%05h status=%0d turn=%0b pc_req=%0b game_over=%0b forced=%0b illegal=%0b, required no event",
                     g.kind.name(), g.board, g.status, g.turn, g.pc_req, g.game_over, g.forced, g.illegal);
            return;
        end
        e = exp_q.pop_front();
        if (g.kind !== e.kind || g.board !== e.board || g.status !== e.status || g.turn !== e.turn ||
            g.pc_req !== e.pc_req || g.game_over !== e.game_over || g.forced !== e.forced ||
            g.illegal !== e.illegal) begin
            n_bad++;
            $display("FAIL %s: got %s board=%05h status=%0d turn=%0b pc_req=%0b game_over=%0b forced=%0b illegal=%0b, required %s board=%05h status=%0d turn=%0b pc_req=%0b game_over=%0b forced=%0b illegal=%0b",
                     e.kind.name(), g.kind.name(), g.board, g.status, g.turn, g.pc_req, g.game_over, g.forced, g.illegal,
                     e.kind.name(), e.board, e.status, e.turn, e.pc_req, e.game_over, e.forced, e.illegal);
        end
    endtask

    // Monitor: turn every output change or pulse into one classified event.
    initial begin
        snap_t prev, cur;
        bit    in_rst;
        in_rst = 1'b0;
        prev.kind = K_OTHER; prev.board = '0; prev.status = '0; prev.turn = 1'b0;
        prev.pc_req = 1'b0; prev.game_over = 1'b0; prev.forced = 1'b0; prev.illegal = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            cur.kind = K_OTHER; cur.board = board; cur.status = status; cur.turn = turn;
            cur.pc_req = pc_req; cur.game_over = game_over; cur.forced = forced; cur.illegal = illegal;
            if (reset) begin
                if (!in_rst) begin
                    cur.kind = K_RESET;
                    check_ev(cur);
                end
                in_rst = 1'b1;
            end else begin
                in_rst = 1'b0;
                if (cur.board !== prev.board || cur.status !== prev.status || cur.turn !== prev.turn ||
                    cur.pc_req !== prev.pc_req || cur.game_over !== prev.game_over ||
                    cur.illegal !== 1'b0 || cur.forced !== 1'b0) begin
                    if (cur.board == '0 && prev.board != '0)      cur.kind = K_CLEAR;
                    else if (cur.board !== prev.board)            cur.kind = K_COMMIT;
                    else if (cur.illegal)                         cur.kind = K_ILLEGAL;
                    else if (cur.game_over && !prev.game_over)    cur.kind = K_END;
                    else if (cur.turn !== prev.turn)              cur.kind = K_TURN;
                    check_ev(cur);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: got no completion by %0t, required completion", $time);
        summary();
        $finish;
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        start    = 1'b0;
        pl_valid = 1'b0;
        pc_valid = 1'b0;
        pl_sel   = 9'($urandom);
        pc_sel   = 9'($urandom);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        for (int i = 0; i < 9; i++) cells[i] = 0;
        m_turn = 1'b0;
        m_over = 1'b0;
        exp_q.push_back(mk(K_RESET, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic start_game(input bit with_noise);
        clear_inputs();
        start = 1'b1;
        if (with_noise) begin
            pc_valid = 1'b1; pc_sel = rand_empty();
            pl_valid = 1'b1; pl_sel = rand_empty();
        end
        if (m_board() != '0) begin
            for (int i = 0; i < 9; i++) cells[i] = 0;
            exp_q.push_back(mk(K_CLEAR, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        for (int i = 0; i < 9; i++) cells[i] = 0;
        m_turn = 1'b0;
        m_over = 1'b0;
        tick();
        clear_inputs();
    endtask

    // Player turn: d non-committing cycles, then a legal move unless the timeout comes first.
    task automatic player_turn(input int d, input logic [8:0] sel);
        bit fin = 1'b0;
        for (int j = 1; !fin; j++) begin
            clear_inputs();
            if (j == d + 1) begin
                pl_valid = 1'b1;
                pl_sel   = sel;
                cells[sel_index(sel)] = 1;
                exp_q.push_back(mk(K_COMMIT, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                fin = 1'b1;
            end else if (j == int'(T)) begin
                cells[lowest_empty()] = 1;
                exp_q.push_back(mk(K_COMMIT, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
                fin = 1'b1;
            end else if (bad_q.size() != 0) begin
                pl_valid = 1'b1;
                pl_sel   = bad_q.pop_front();
                exp_q.push_back(mk(K_ILLEGAL, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            end else begin
                case ($urandom_range(0, 2))
                    0: ;
                    1: begin
                        pl_valid = 1'b1;
                        pl_sel   = bad_sel();
                        exp_q.push_back(mk(K_ILLEGAL, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
                    end
                    default: begin
                        pc_valid = 1'b1;
                        pc_sel   = rand_empty();
                    end
                endcase
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic pc_turn(input int n_noise, input logic [8:0] sel);
        int w = 0;
        while (pc_req !== 1'b1 && w < 4) begin
            tick();
            w++;
        end
        if (pc_req !== 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL pc_req_wait: got pc_req=%b after %0d cycles, required 1", pc_req, w);
            summary();
            $finish;
        end
        for (int k = 0; k < n_noise; k++) begin
            clear_inputs();
            case ($urandom_range(0, 2))
                0: ;
                1: begin
                    pc_valid = 1'b1;
                    pc_sel   = bad_sel();
                    exp_q.push_back(mk(K_ILLEGAL, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
                end
                default: begin
                    pl_valid = 1'b1;
                    pl_sel   = rand_empty();
                end
            endcase
            tick();
        end
        clear_inputs();
        pc_valid = 1'b1;
        pc_sel   = sel;
        cells[sel_index(sel)] = 2;
        exp_q.push_back(mk(K_COMMIT, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        clear_inputs();
    endtask

    // One evaluation cycle: game ends on a line or full board, otherwise the turn passes.
    task automatic eval_step();
        int win;
        clear_inputs();
        pl_valid = 1'($urandom);
        pl_sel   = any_onehot();
        pc_valid = 1'($urandom);
        pc_sel   = any_onehot();
        win = m_winner();
        if (win != 0 || m_full()) begin
            m_over = 1'b1;
            exp_q.push_back(mk(K_END, (win != 0) ? 2'(win) : 2'd3, m_turn, 1'b0, 1'b1, 1'b0, 1'b0));
        end else begin
            m_turn = !m_turn;
            exp_q.push_back(mk(K_TURN, 2'd0, m_turn, m_turn, 1'b0, 1'b0, 1'b0));
        end
        tick();
        clear_inputs();
    endtask

    task automatic idle_noise(input int n);
        for (int k = 0; k < n; k++) begin
            clear_inputs();
            pl_valid = 1'($urandom);
            pl_sel   = any_onehot();
            pc_valid = 1'($urandom);
            pc_sel   = any_onehot();
            tick();
        end
        clear_inputs();
    endtask

    // Alternating moves from mv[0..n-1], player first, each followed by evaluation.
    task automatic play_moves(input int n);
        for (int i = 0; i < n && !m_over; i++) begin
            if (i % 2 == 0) player_turn(0, onehot_of(mv[i]));
            else            pc_turn(0, onehot_of(mv[i]));
            eval_step();
        end
    endtask

    task automatic play_random();
        start_game(1'($urandom));
        while (!m_over) begin
            player_turn(int'($urandom_range(0, T + 2)), rand_empty());
            eval_step();
            if (m_over) break;
            if ($urandom_range(0, 15) == 0) begin
                start_game(1'b1);
                continue;
            end
            pc_turn(int'($urandom_range(0, 3)), rand_empty());
            eval_step();
        end
        idle_noise(3);
    endtask

    initial begin
        clear_inputs();
        do_reset();
        idle_noise(3);

        // Player wins on the top row; later strobes in DONE are ignored.
        start_game(1'b0);
        mv = '{0, 3, 1, 4, 2, 0, 0, 0, 0};
        play_moves(5);
        idle_noise(4);

        // Rejected player strobes, then a start in PC_WAIT that beats a PC strobe.
        start_game(1'b0);
        mv = '{4, 0, 0, 0, 0, 0, 0, 0, 0};
        play_moves(2);
        bad_q.push_back(9'h003);
        bad_q.push_back(9'h001);
        player_turn(2, 9'h002);
        eval_step();
        start_game(1'b1);

        // Timeout forces cell 2; a legal strobe on the timeout cycle still wins; reset during EVAL.
        mv = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        play_moves(2);
        player_turn(int'(T) + 3, 9'h000);
        eval_step();
        pc_turn(1, 9'h010);
        eval_step();
        player_turn(int'(T) - 1, 9'h008);
        do_reset();
        idle_noise(3);

        // Full board with no line ends in a draw.
        start_game(1'b0);
        mv = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        play_moves(9);
        idle_noise(2);

        for (int g = 0; g < 40; g++) play_random();

        idle_noise(4);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d expected events never seen, required 0", exp_q.size());
        end
        summary();
        $finish;
    end

endmodule
